// File: rtl/cache_config_pkg.sv
// Shared bus/snoop encodings, FSM state type and default parameters for the
// snoop bus responder.
package cache_config_pkg;

    typedef enum logic [1:0] {
        READ       = 2'd0,
        WRITE      = 2'd1,
        INVALIDATE = 2'd2,
        RWIM       = 2'd3
    } bus_op_t;

    typedef enum logic [1:0] {
        NOHIT = 2'd0,
        HIT   = 2'd1,
        HITM  = 2'd2
    } snoop_result_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SNOOP   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_MEM     = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    // Peers may drive this encoding; it is outside snoop_result_t.
    localparam logic [1:0] RESULT_ILLEGAL = 2'b11;

    localparam int DEF_NUM_PEERS     = 3;
    localparam int DEF_SNOOP_TIMEOUT = 8;
    localparam int DEF_MEM_LATENCY   = 4;

endpackage

// File: rtl/snoop_result_merge.sv
// Combinational priority merge of per-peer snoop results (HITM > HIT > NOHIT).
// Masked-off peers count as NOHIT; an illegal encoding counts as NOHIT and is flagged.
module snoop_result_merge
    import cache_config_pkg::*;
#(
    parameter int NUM_PEERS = DEF_NUM_PEERS
) (
    input  logic [NUM_PEERS-1:0]   valid_i,
    input  logic [2*NUM_PEERS-1:0] result_i,
    output snoop_result_t          merged_o,
    output logic                   illegal_o
);

    snoop_result_t merged;
    logic          illegal;

    always_comb begin
        merged  = NOHIT;
        illegal = 1'b0;
        for (int k = 0; k < NUM_PEERS; k++) begin
            if (valid_i[k]) begin
                if (result_i[2*k +: 2] == RESULT_ILLEGAL) begin
                    illegal = 1'b1;
                end else if (result_i[2*k +: 2] == HITM) begin
                    merged = HITM;
                end else if ((result_i[2*k +: 2] == HIT) && (merged != HITM)) begin
                    merged = HIT;
                end
            end
        end
    end

    assign merged_o  = merged;
    assign illegal_o = illegal;

endmodule

// File: rtl/snoop_bus_responder.sv
// Snoop bus responder: broadcasts an LLC request to the peers, collects and
// merges their results, optionally accesses memory, then returns the merged result.
//
// state   | meaning
// IDLE    | ready for a new request
// SNOOP   | one-cycle broadcast of the latched op/address
// COLLECT | gather peer results until all seen or timeout
// MEM     | memory access (doubled when a peer holds the line modified)
// RESP    | hold response until the LLC accepts it
module snoop_bus_responder
    import cache_config_pkg::*;
#(
    parameter int NUM_PEERS     = DEF_NUM_PEERS,
    parameter int SNOOP_TIMEOUT = DEF_SNOOP_TIMEOUT,
    parameter int MEM_LATENCY   = DEF_MEM_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [31:0]            req_addr,
    output logic                   snoop_valid,
    output logic [1:0]             snoop_op,
    output logic [31:0]            snoop_addr,
    input  logic [NUM_PEERS-1:0]   peer_valid,
    input  logic [2*NUM_PEERS-1:0] peer_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_result,
    output logic [1:0]             err,
    output logic [15:0]            txn_count
);

    localparam int TW = $clog2(SNOOP_TIMEOUT + 1);
    localparam int MW = $clog2(2 * MEM_LATENCY + 1);
    localparam logic [TW-1:0] TO_LOAD     = TW'(SNOOP_TIMEOUT - 1);
    localparam logic [MW-1:0] MEM_LOAD    = MW'(MEM_LATENCY - 1);
    localparam logic [MW-1:0] MEM_LOAD_WB = MW'(2 * MEM_LATENCY - 1);

    state_t                 state_q, state_d;
    bus_op_t                op_q;
    logic [31:0]            addr_q;
    logic [NUM_PEERS-1:0]   seen_q;
    logic [2*NUM_PEERS-1:0] res_q;
    logic [TW-1:0]          to_cnt_q;
    logic [MW-1:0]          mem_cnt_q;
    snoop_result_t          rsp_result_q;
    logic [1:0]             err_q;
    logic [15:0]            txn_q;

    logic                   accept;
    logic [NUM_PEERS-1:0]   new_strobe;
    logic [NUM_PEERS-1:0]   eff_valid;
    logic [2*NUM_PEERS-1:0] eff_result;
    logic                   all_seen;
    logic                   collect_exit;
    snoop_result_t          merged;
    logic                   illegal;

    assign accept       = req_valid && (state_q == ST_IDLE);
    assign new_strobe   = (state_q == ST_COLLECT) ? (peer_valid & ~seen_q) : '0;
    assign eff_valid    = seen_q | new_strobe;
    assign all_seen     = &eff_valid;
    assign collect_exit = (state_q == ST_COLLECT) && (all_seen || (to_cnt_q == '0));

    // A peer's first strobe wins; later strobes in the same transaction are ignored.
    always_comb begin
        eff_result = '0;
        for (int k = 0; k < NUM_PEERS; k++) begin
            eff_result[2*k +: 2] = seen_q[k] ? res_q[2*k +: 2] : peer_result[2*k +: 2];
        end
    end

    snoop_result_merge #(
        .NUM_PEERS (NUM_PEERS)
    ) u_merge (
        .valid_i   (eff_valid),
        .result_i  (eff_result),
        .merged_o  (merged),
        .illegal_o (illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (req_valid) state_d = ST_SNOOP;
            ST_SNOOP:   state_d = ST_COLLECT;
            ST_COLLECT: if (collect_exit) state_d = (op_q == INVALIDATE) ? ST_RESP : ST_MEM;
            ST_MEM:     if (mem_cnt_q == '0) state_d = ST_RESP;
            ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == ST_IDLE);
        snoop_valid = (state_q == ST_SNOOP);
        rsp_valid   = (state_q == ST_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= READ;
            addr_q       <= '0;
            seen_q       <= '0;
            res_q        <= '0;
            to_cnt_q     <= '0;
            mem_cnt_q    <= '0;
            rsp_result_q <= NOHIT;
            err_q        <= '0;
            txn_q        <= '0;
        end else begin
            if (accept) begin
                op_q   <= bus_op_t'(req_op);
                addr_q <= req_addr;
                seen_q <= '0;
                res_q  <= '0;
            end

            if (state_q == ST_SNOOP) begin
                to_cnt_q <= TO_LOAD;
            end else if ((state_q == ST_COLLECT) && (to_cnt_q != '0)) begin
                to_cnt_q <= to_cnt_q - 1'b1;
            end

            if (state_q == ST_COLLECT) begin
                seen_q <= eff_valid;
                for (int k = 0; k < NUM_PEERS; k++) begin
                    if (new_strobe[k]) res_q[2*k +: 2] <= peer_result[2*k +: 2];
                end
                if (illegal) err_q[1] <= 1'b1;
            end

            // Silent peers at timeout are simply absent from the merge, i.e. NOHIT.
            if (collect_exit) begin
                rsp_result_q <= merged;
                mem_cnt_q    <= (merged == HITM) ? MEM_LOAD_WB : MEM_LOAD;
                if (!all_seen) err_q[0] <= 1'b1;
            end else if ((state_q == ST_MEM) && (mem_cnt_q != '0)) begin
                mem_cnt_q <= mem_cnt_q - 1'b1;
            end

            if ((state_q == ST_RESP) && rsp_ready) begin
                txn_q <= txn_q + 16'd1;
            end
        end
    end

    assign snoop_op   = op_q;
    assign snoop_addr = addr_q;
    assign rsp_result = rsp_result_q;
    assign err        = err_q;
    assign txn_count  = txn_q;

endmodule

// File: tb/tb_snoop_bus_responder.sv
// Scoreboard bench for snoop_bus_responder: directed transactions push expected
// responses; a negedge monitor pops and compares on every response handshake.
module tb_snoop_bus_responder;
    import cache_config_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic        snoop_valid;
    logic [1:0]  snoop_op;
    logic [31:0] snoop_addr;
    logic [2:0]  peer_valid;
    logic [5:0]  peer_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_result;
    logic [1:0]  err;
    logic [15:0] txn_count;

    always #5 clk = ~clk;

    snoop_bus_responder #(
        .NUM_PEERS     (3),
        .SNOOP_TIMEOUT (8),
        .MEM_LATENCY   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .snoop_valid (snoop_valid),
        .snoop_op    (snoop_op),
        .snoop_addr  (snoop_addr),
        .peer_valid  (peer_valid),
        .peer_result (peer_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .err         (err),
        .txn_count   (txn_count)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [1:0]  result;
        logic [1:0]  errv;
        int          lat;
        logic [15:0] txn;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: latency is counted in cycles from the acceptance cycle (index 0).
    int   lat = 0;
    bit   tracking = 0;
    bit   rsp_seen = 0;
    int   lat_rsp = 0;
    int   snoop_cnt = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            tracking  = 0;
            rsp_seen  = 0;
            snoop_cnt = 0;
        end else begin
            if (tracking) lat++;
            if (req_valid && req_ready) begin
                tracking = 1;
                lat      = 0;
            end
            if (snoop_valid) begin
                snoop_cnt++;
                if (sb.size() > 0) begin
                    chk("snoop_op", {30'd0, snoop_op}, {30'd0, sb[0].op});
                    chk("snoop_addr", snoop_addr, sb[0].addr);
                end
            end
            if (rsp_valid && !rsp_seen) begin
                rsp_seen = 1;
                lat_rsp  = lat;
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: got result %0h expected no response", rsp_result);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_result", {30'd0, rsp_result}, {30'd0, mon_e.result});
                    chk("err", {30'd0, err}, {30'd0, mon_e.errv});
                    chk("rsp_latency", lat_rsp, mon_e.lat);
                    chk("txn_before", {16'd0, txn_count}, {16'd0, mon_e.txn});
                    chk("snoop_pulses", snoop_cnt, 1);
                end
                tracking  = 0;
                rsp_seen  = 0;
                snoop_cnt = 0;
            end
        end
    end

    task automatic run_txn(
        input logic [1:0]  op,
        input logic [31:0] addr,
        input int c0, input logic [1:0] r0,
        input int c1, input logic [1:0] r1,
        input int c2, input logic [1:0] r2,
        input int dupc, input logic [1:0] dupr,
        input bit snoop_pulse,
        input bit expect_rsp,
        input logic [1:0]  e_res,
        input logic [1:0]  e_err,
        input int          e_lat,
        input logic [15:0] e_txn
    );
        exp_t e;
        int   last;
        bit   ok;
        req_op    = op;
        req_addr  = addr;
        req_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: got req_ready 0 expected 1 within 200 cycles");
            req_valid = 1'b0;
            return;
        end
        if (expect_rsp) begin
            e.op = op; e.addr = addr; e.result = e_res; e.errv = e_err;
            e.lat = e_lat; e.txn = e_txn;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (snoop_pulse) begin
            peer_valid  = 3'b111;
            peer_result = 6'b10_10_10;
        end
        @(posedge clk); #1;
        last = c0;
        if (c1 > last) last = c1;
        if (c2 > last) last = c2;
        if (dupc > last) last = dupc;
        for (int c = 1; c <= last; c++) begin
            peer_valid  = '0;
            peer_result = '0;
            if (c0 == c)   begin peer_valid[0] = 1'b1; peer_result[1:0] = r0;   end
            if (dupc == c) begin peer_valid[0] = 1'b1; peer_result[1:0] = dupr; end
            if (c1 == c)   begin peer_valid[1] = 1'b1; peer_result[3:2] = r1;   end
            if (c2 == c)   begin peer_valid[2] = 1'b1; peer_result[5:4] = r2;   end
            @(posedge clk); #1;
        end
        peer_valid  = '0;
        peer_result = '0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((sb.size() == 0) && req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_ready"},   {31'd0, req_ready},   32'd1);
        chk({tag, "_snoop_valid"}, {31'd0, snoop_valid}, 32'd0);
        chk({tag, "_rsp_valid"},   {31'd0, rsp_valid},   32'd0);
        chk({tag, "_snoop_op"},    {30'd0, snoop_op},    32'd0);
        chk({tag, "_snoop_addr"},  snoop_addr,           32'd0);
        chk({tag, "_rsp_result"},  {30'd0, rsp_result},  {30'd0, NOHIT});
        chk({tag, "_err"},         {30'd0, err},         32'd0);
        chk({tag, "_txn_count"},   {16'd0, txn_count},   32'd0);
    endtask

    initial begin
        bit ok;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_op      = 2'd0;
        req_addr    = 32'd0;
        peer_valid  = '0;
        peer_result = '0;
        rsp_ready   = 1'b1;
        #12;
        chk_reset_values("por");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // READ, all NOHIT in first COLLECT cycle: 3 + 4 = 7
        run_txn(READ, 32'h0000_1000, 1, NOHIT, 1, NOHIT, 1, NOHIT, 0, NOHIT, 0, 1,
                NOHIT, 2'b00, 7, 16'd0);
        wait_idle();
        chk("txn_after_first", {16'd0, txn_count}, 32'd1);

        // RWIM with HIT/HITM/NOHIT: HITM, MEM doubled: 3 + 8 = 11
        run_txn(RWIM, 32'hA5A5_0040, 1, HIT, 1, HITM, 1, NOHIT, 0, NOHIT, 0, 1,
                HITM, 2'b00, 11, 16'd1);
        wait_idle();

        // INVALIDATE with peer 2 silent: 8 COLLECT cycles then RESP: 2 + 8 = 10
        run_txn(INVALIDATE, 32'h0000_2080, 1, HIT, 2, NOHIT, 0, NOHIT, 0, NOHIT, 0, 1,
                HIT, 2'b01, 10, 16'd2);
        wait_idle();
        chk("err_after_timeout", {30'd0, err}, 32'd1);

        // READ with staggered peers, then a 5-cycle stall with the next request pending
        rsp_ready = 1'b0;
        run_txn(READ, 32'h0000_3000, 1, HIT, 2, NOHIT, 3, NOHIT, 0, NOHIT, 0, 1,
                HIT, 2'b01, 9, 16'd3);
        req_op    = INVALIDATE;
        req_addr  = 32'h0000_4000;
        req_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL stall_wait: got rsp_valid 0 expected 1 within 50 cycles");
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid",  {31'd0, rsp_valid},  32'd1);
            chk("stall_rsp_result", {30'd0, rsp_result}, {30'd0, HIT});
            chk("stall_req_ready",  {31'd0, req_ready},  32'd0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;

        // Peer 0 sends illegal then a duplicate HITM: counted once as NOHIT
        run_txn(INVALIDATE, 32'h0000_4000, 1, 2'b11, 3, NOHIT, 3, NOHIT, 2, HITM, 0, 1,
                NOHIT, 2'b11, 5, 16'd4);
        wait_idle();
        chk("err_after_illegal", {30'd0, err}, 32'd3);

        // HITM strobes in IDLE and SNOOP must not count
        peer_valid  = 3'b111;
        peer_result = 6'b10_10_10;
        @(posedge clk); #1;
        peer_valid  = '0;
        peer_result = '0;
        run_txn(WRITE, 32'h0000_5000, 1, NOHIT, 1, NOHIT, 1, NOHIT, 0, NOHIT, 1, 1,
                NOHIT, 2'b11, 7, 16'd5);
        wait_idle();

        // Reset during MEM abandons the transaction
        run_txn(READ, 32'h0000_6000, 1, NOHIT, 1, NOHIT, 1, NOHIT, 0, NOHIT, 0, 0,
                NOHIT, 2'b00, 0, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset_values("mid_mem");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;

        run_txn(WRITE, 32'h0000_7000, 1, HIT, 1, HIT, 1, HIT, 0, NOHIT, 0, 1,
                HIT, 2'b00, 7, 16'd0);
        wait_idle();
        chk("txn_after_reset", {16'd0, txn_count}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/snoop_bus_responder.md
SNOOP_BUS_RESPONDER -- requirements
Module: snoop_bus_responder

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_PEERS, 3, number of peer snoopers.
- SNOOP_TIMEOUT, 8, maximum COLLECT cycles.
- MEM_LATENCY, 4, cycles per memory access; must be at least 1.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, the only clock.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, bus request from the LLC.
- req_ready, out, 1, responder can accept a request.
- req_op, in, 2, bus_op_t.
- req_addr, in, 32, line address.
- snoop_valid, out, 1, broadcast strobe to the peers.
- snoop_op, out, 2, latched bus_op_t.
- snoop_addr, out, 32, latched address.
- peer_valid, in, NUM_PEERS, per-peer result strobe.
- peer_result, in, 2*NUM_PEERS, snoop_result_t per peer; peer k uses bits [2k+1:2k].
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, LLC accepts the response.
- rsp_result, out, 2, merged snoop_result_t.
- err, out, 2, sticky: bit0 timeout, bit1 illegal result.
- txn_count, out, 16, completed transactions; wraps.

REQ-003 One clock; reset is asynchronous and active-low.

Function
REQ-010 The FSM SHALL have the states IDLE, SNOOP, COLLECT, MEM, RESP.

REQ-011 req_ready SHALL be 1 only in IDLE. On req_valid&&req_ready, the block latches req_op and req_addr and moves to SNOOP.

REQ-012 SNOOP SHALL last exactly one cycle:
- snoop_valid=1 with the latched op and address.
- Next state is COLLECT.
- snoop_op and snoop_addr hold their latched values until the next acceptance.

REQ-013 In COLLECT, peer_valid[k] SHALL set a sticky seen-mask bit and capture that peer's result. A repeated strobe from the same peer in the same transaction is ignored.

REQ-014 peer_valid SHALL be ignored outside COLLECT.

REQ-015 COLLECT exit SHALL occur in the cycle where the seen-mask OR incoming peer_valid is all-ones. That cycle's results are included in the merge.

REQ-016 Timeout: if the mask is incomplete after SNOOP_TIMEOUT COLLECT cycles, missing peers count as NOHIT, err[0] is set, and COLLECT exits.

REQ-017 Merge priority SHALL be HITM > HIT > NOHIT.

REQ-018 A peer result encoding of 2'b11 SHALL be treated as NOHIT and SHALL set err[1].

REQ-019 Exit from COLLECT SHALL route as follows:
- INVALIDATE goes to RESP.
- READ, WRITE and RWIM go to MEM.

REQ-020 MEM SHALL last MEM_LATENCY cycles, or 2*MEM_LATENCY if the merged result is HITM (peer writeback, then access), then go to RESP.

REQ-021 RESP SHALL hold rsp_valid=1 and a stable rsp_result until rsp_ready. On the handshake:
- txn_count increments, wrapping 16'hFFFF to 0.
- Next state is IDLE.

REQ-022 Minimum latency, counted from the acceptance edge:
- rsp_valid is asserted 3 cycles after acceptance when no memory access is needed.
- Add MEM_LATENCY (or 2*MEM_LATENCY on HITM) otherwise.

REQ-023 A req_valid asserted while req_ready=0 SHALL be neither lost nor accepted. The requester holds it until IDLE.

REQ-024 err bits SHALL clear only on reset.

Reset
REQ-030 On rst_n=0, asynchronously:
- state=IDLE.
- req_ready=1.
- snoop_valid=0, rsp_valid=0.
- snoop_op=0, snoop_addr=0.
- rsp_result=NOHIT.
- err=0, txn_count=0.
- Mask and counters cleared.

REQ-031 A reset mid-transaction SHALL abandon it with no response. The first cycle after release is IDLE.

Structure
REQ-040 The following SHALL live in cache_config_pkg:
- bus_op_t: READ=0, WRITE=1, INVALIDATE=2, RWIM=3.
- snoop_result_t: NOHIT=0, HIT=1, HITM=2.
- Default parameter constants.

REQ-041 The merge logic SHALL be a combinational sub-module, snoop_result_merge, parameterized by NUM_PEERS.

Verification
REQ-050 READ, all peers NOHIT in the first COLLECT cycle, MEM_LATENCY=4 -> rsp_valid 7 cycles after acceptance, rsp_result=NOHIT, txn_count=1.

REQ-051 RWIM with peer results HIT, HITM, NOHIT -> rsp_result=HITM, MEM lasts 8 cycles, rsp_valid 11 cycles after acceptance.

REQ-052 INVALIDATE with peer 2 silent -> after 8 COLLECT cycles, err=2'b01, rsp_result is the merge of peers 0 and 1.

REQ-053 rsp_ready held 0 for 5 cycles in RESP, with req_valid=1 throughout -> rsp_valid and rsp_result stable, req_ready=0, no second snoop_valid.

REQ-054 Peer 0 sends 2'b11 and then a duplicate strobe -> err[1]=1, result counted as NOHIT once; peer_valid pulses in IDLE are ignored.

REQ-055 rst_n pulsed low during MEM -> outputs reach their reset values immediately, no rsp_valid, and the next request completes normally.
